// File: rtl/fetch_unit_if.sv
// Instruction-memory bus between the fetch stage and the instruction memory.
//   req    : fetch request valid (master -> slave)
//   addr   : fetch byte address  (master -> slave)
//   ready  : memory accepts the request this cycle (slave -> master)
//   rvalid : response data valid (slave -> master)
//   rdata  : response instruction word (slave -> master)
interface fetch_unit_if;
    localparam int unsigned XLEN = 32;

    logic            req;
    logic [XLEN-1:0] addr;
    logic            ready;
    logic            rvalid;
    logic [XLEN-1:0] rdata;

    modport master (output req, addr, input ready, rvalid, rdata);
    modport slave  (input req, addr, output ready, rvalid, rdata);
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds PCF, issues single-outstanding fetches over
// the imem bus, squashes wrong-path work on redirects from execute and absorbs
// decode stalls in a one-entry skid buffer in front of the IF/ID register.
//   clk, rst     : clock, synchronous active-high reset
//   StallF       : block new fetch requests
//   StallD       : hold the IF/ID register
//   PCSrcE       : redirect from execute, target on PCTargetE
//   imem         : instruction-memory bus (master side)
//   InstrD, PCD, PCPlus4D, ValidD : IF/ID register outputs
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                StallF,
    input  logic                StallD,
    input  logic                PCSrcE,
    input  logic [31:0]         PCTargetE,
    fetch_unit_if.master        imem,
    output logic [31:0]         InstrD,
    output logic [31:0]         PCD,
    output logic [31:0]         PCPlus4D,
    output logic                ValidD
);
    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pcf_q, pcf_d;
    logic [XLEN-1:0] pc_inflight_q, pc_inflight_d;
    logic            buf_valid_q, buf_valid_d;
    logic [XLEN-1:0] buf_instr_q, buf_instr_d;
    logic [XLEN-1:0] buf_pc_q, buf_pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pcd_q, pcd_d;
    logic [XLEN-1:0] pcplus4_q, pcplus4_d;
    logic            valid_q, valid_d;

    logic            req;
    logic            accept;
    logic            resp;

    // State and IF/ID register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= REQ;
            pcf_q         <= RESET_PC;
            pc_inflight_q <= '0;
            buf_valid_q   <= 1'b0;
            buf_instr_q   <= '0;
            buf_pc_q      <= '0;
            instr_q       <= NOP_INSTR;
            pcd_q         <= '0;
            pcplus4_q     <= '0;
            valid_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pcf_q         <= pcf_d;
            pc_inflight_q <= pc_inflight_d;
            buf_valid_q   <= buf_valid_d;
            buf_instr_q   <= buf_instr_d;
            buf_pc_q      <= buf_pc_d;
            instr_q       <= instr_d;
            pcd_q         <= pcd_d;
            pcplus4_q     <= pcplus4_d;
            valid_q       <= valid_d;
        end
    end

    // Next-state, request and delivery logic
    always_comb begin
        state_d       = state_q;
        pcf_d         = pcf_q;
        pc_inflight_d = pc_inflight_q;
        buf_valid_d   = buf_valid_q;
        buf_instr_d   = buf_instr_q;
        buf_pc_d      = buf_pc_q;
        instr_d       = instr_q;
        pcd_d         = pcd_q;
        pcplus4_d     = pcplus4_q;
        valid_d       = valid_q;

        // No new request while a buffered instruction is waiting: keeps the
        // skid buffer from ever needing a second entry.
        req    = (state_q == REQ) & ~StallF & ~buf_valid_q & ~PCSrcE & ~rst;
        accept = req & imem.ready;
        // Only a response in WAIT is on the correct path.
        resp   = (state_q == WAIT) & imem.rvalid & ~PCSrcE;

        if (PCSrcE) begin
            // Redirect wins over everything, including a decode stall.
            pcf_d       = PCTargetE;
            instr_d     = NOP_INSTR;
            valid_d     = 1'b0;
            buf_valid_d = 1'b0;
            if (state_q != REQ) begin
                // Outstanding response either arrives now (discard) or later (DROP).
                state_d = imem.rvalid ? REQ : DROP;
            end
        end else begin
            if (accept) begin
                pc_inflight_d = pcf_q;
                pcf_d         = pcf_q + PC_STEP;
                state_d       = WAIT;
            end else if ((state_q != REQ) && imem.rvalid) begin
                state_d = REQ;
            end

            if (!StallD) begin
                if (buf_valid_q) begin
                    instr_d     = buf_instr_q;
                    pcd_d       = buf_pc_q;
                    pcplus4_d   = buf_pc_q + PC_STEP;
                    valid_d     = 1'b1;
                    buf_valid_d = 1'b0;
                end else if (resp) begin
                    instr_d   = imem.rdata;
                    pcd_d     = pc_inflight_q;
                    pcplus4_d = pc_inflight_q + PC_STEP;
                    valid_d   = 1'b1;
                end else begin
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                end
            end else if (resp) begin
                buf_valid_d = 1'b1;
                buf_instr_d = imem.rdata;
                buf_pc_d    = pc_inflight_q;
            end
        end
    end

    assign imem.req  = req;
    assign imem.addr = pcf_q;

    assign InstrD   = instr_q;
    assign PCD      = pcd_q;
    assign PCPlus4D = pcplus4_q;
    assign ValidD   = valid_q;
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the RV32I 5-stage pipeline, the consumer of the execute stage's branch outputs (PCSrcE, PCTargetE). Holds the fetch PC, issues single-outstanding requests to a variable-latency instruction memory over a req/ready + rvalid handshake, and drives the IF/ID pipeline register. Redirects from execute squash wrong-path work. Stalls from the hazard unit are absorbed by a one-entry skid buffer.

## Interface
- RESET_PC, 32'h0000_0000, fetch address after reset
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) loaded into IF/ID
- Reset is rst, synchronous, active-high; clock is clk.
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- StallF  in  1  hazard unit: issue no new fetch request
- StallD  in  1  hazard unit: hold the IF/ID register
- PCSrcE  in  1  redirect from execute (jump or taken branch)
- PCTargetE  in  32  redirect target
- imem_req  out  1  request valid
- imem_addr  out  32  request address (= PCF)
- imem_ready  in  1  memory accepts the request this cycle
- imem_rvalid  in  1  response data valid
- imem_rdata  in  32  response instruction
- InstrD  out  32  IF/ID instruction
- PCD  out  32  IF/ID PC
- PCPlus4D  out  32  IF/ID PC+4
- ValidD  out  1  IF/ID holds a real instruction

## Operation
- Registers: PCF, pc_inflight, state {REQ, WAIT, DROP}, 1-entry buffer (buf_valid, buf_instr, buf_pc), IF/ID outputs.
- imem_req = (state==REQ) & ~StallF & ~buf_valid & ~PCSrcE & ~rst; imem_addr = PCF.
- Accept = imem_req & imem_ready: pc_inflight<=PCF, PCF<=PCF+4 (mod 2^32, wraps), REQ->WAIT.
- WAIT, imem_rvalid: response (imem_rdata, pc_inflight) is delivered; ->REQ.
- DROP, imem_rvalid: response discarded; ->REQ.
- Delivery, when StallD=0: buf_valid -> IF/ID <= buffer, buf_valid<=0; else response this cycle -> IF/ID <= response; else IF/ID <= {NOP_INSTR, ValidD=0}, PCD/PCPlus4D hold.
- Delivery, when StallD=1: IF/ID holds; a response arriving goes into the buffer (buf_valid<=1).
- At most one outstanding request. A new request is never issued while buf_valid=1. The buffer therefore never overflows.
- PCPlus4D = PCD+4, loaded together with PCD.
- Redirect (PCSrcE=1) has priority over everything, including StallD:
  - PCF<=PCTargetE; IF/ID <= {NOP_INSTR, ValidD=0}; buf_valid<=0.
  - If state==WAIT and no rvalid this cycle: ->DROP.
  - If rvalid this cycle (WAIT or DROP): response discarded; ->REQ.
  - If in REQ: stay REQ; no request issued this cycle.
- Redirect while already in DROP without rvalid: stay DROP; PCF updated to the newest target.
- StallF only blocks new requests. An outstanding response is still accepted into IF/ID or the buffer.

## Timing
- Reset values: PCF=RESET_PC, state=REQ, buf_valid=0, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0, imem_req=0 while rst=1.
- Reset mid-transaction: the outstanding response is ignored. The next rvalid after reset deasserts must not occur without a new accept; the memory is reset together with this block.
- First request is issued in the first cycle after rst deasserts.
- imem_ready may be combinational in the same cycle. rvalid arrives no earlier than 1 cycle after accept.
- Best-case throughput: 1 instruction per 2 cycles (accept, respond).
- Instruction-delivery latency: accept at cycle N, rvalid at N+k, IF/ID valid at N+k+1.
- Redirect at cycle N: IF/ID is a bubble at N+1, and a request to PCTargetE can be issued at N+1 (from REQ).

## Test plan
- Reset, RESET_PC=0, memory with 1-cycle latency returning word addr>>2 -> imem_addr 0,4,8; InstrD 0,1,2 with PCD 0,4,8, ValidD=1 every 2nd cycle, NOP between.
- Latency 3 with random ready gaps -> in-order PCD sequence, exactly one outstanding request, no lost or duplicated instruction.
- StallD=1 for 4 cycles while response for PC 0x10 arrives -> IF/ID held, buf_valid=1, no imem_req; StallD release -> PCD=0x10 next cycle, then fetch resumes at 0x14.
- PCSrcE=1, target 0x100, in WAIT for PC 0x20, rvalid 2 cycles later -> 0x20 response dropped, ValidD=0, next imem_addr=0x100, PCD=0x100 delivered.
- PCSrcE=1 same cycle as rvalid and StallD=1 with buf_valid=1 -> buffer and response discarded, IF/ID bubble, next request at target.
- StallF=1 for 3 cycles in REQ -> imem_req=0, PCF unchanged; release -> request at the held PCF.
